ide_pio_sequencer: RTL and testbench

//  Sequences one IDE PIO register/data transfer per Zorro II cycle to the ATA t1/t2/t2i/IORDY timing rules.

---
 rtl/ide_pio_sequencer_pkg.sv | 28 ++
 rtl/ide_pio_sequencer_sync2.sv | 24 ++
 rtl/ide_pio_sequencer.sv | 150 +++++++++++++++
 tb/tb_ide_pio_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ide_pio_sequencer_pkg.sv
// Shared state encoding, default ATA PIO timing constants and counter-load helpers
// for the IDE PIO strobe sequencer.
package ide_pio_sequencer_pkg;

   typedef enum logic [2:0] {
      PIO_IDLE     = 3'd0,
      PIO_SETUP    = 3'd1,
      PIO_STROBE   = 3'd2,
      PIO_WAIT_RDY = 3'd3,
      PIO_ACK      = 3'd4,
      PIO_RECOVER  = 3'd5
   } pio_state_t;

   localparam int DEF_T1_CYC      = 2;
   localparam int DEF_T2_CYC      = 4;
   localparam int DEF_T2I_CYC     = 2;
   localparam int DEF_RDY_TIMEOUT = 64;

   // Counters run from N-1 down to 0, so a phase of N cycles loads N-1.
   function automatic logic [3:0] cyc_load4(input int n);
      return (n > 0) ? 4'(n - 1) : 4'd0;
   endfunction

   function automatic logic [7:0] cyc_load8(input int n);
      return (n > 0) ? 8'(n - 1) : 8'd0;
   endfunction

endpackage

// File: rtl/ide_pio_sequencer_sync2.sv
// Generic two-flop synchroniser with a selectable reset value; used to bring the
// asynchronous IDE IORDY line into the clk domain.
module ide_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ide_pio_sequencer.sv
// Sequences one IDE PIO transfer per bus cycle with ATA t1/t2/t2i spacing and
// IORDY stretching; strobes and dtack are registered from the next state.
module ide_pio_sequencer
   import ide_pio_sequencer_pkg::*;
#(
   parameter int T1_CYC      = DEF_T1_CYC,
   parameter int T2_CYC      = DEF_T2_CYC,
   parameter int T2I_CYC     = DEF_T2I_CYC,
   parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       rw,
   input  logic       as_n,
   input  logic       iordy,
   output logic       ior_n,
   output logic       iow_n,
   output logic       dtack,
   output logic       busy,
   output logic       timeout,
   output logic [2:0] state_dbg
);

   localparam logic [3:0] T1_LOAD  = cyc_load4(T1_CYC);
   localparam logic [3:0] T2_LOAD  = cyc_load4(T2_CYC);
   localparam logic [3:0] T2I_LOAD = cyc_load4(T2I_CYC);
   localparam logic [7:0] RDY_LOAD = cyc_load8(RDY_TIMEOUT);

   pio_state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] tcnt, tcnt_nxt;
   logic       rw_q, rw_nxt;
   logic       timeout_nxt;
   logic       strobe_nxt;
   logic       iordy_s;

   ide_sync2 #(.RESET_VAL(1'b1)) u_iordy_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (iordy),
      .q       (iordy_s)
   );

   // Handshake: req qualifies the start only while IDLE; after that as_n alone
   // governs the cycle, and dtack stays high until as_n is sampled high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= PIO_IDLE;
         cnt     <= 4'd0;
         tcnt    <= 8'd0;
         rw_q    <= 1'b1;
         ior_n   <= 1'b1;
         iow_n   <= 1'b1;
         dtack   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         tcnt    <= tcnt_nxt;
         rw_q    <= rw_nxt;
         ior_n   <= !(strobe_nxt && rw_nxt);
         iow_n   <= !(strobe_nxt && !rw_nxt);
         dtack   <= (state_nxt == PIO_ACK);
         timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tcnt_nxt    = tcnt;
      rw_nxt      = rw_q;
      timeout_nxt = 1'b0;
      unique case (state)
         PIO_IDLE: begin
            if (req && !as_n) begin
               state_nxt = PIO_SETUP;
               rw_nxt    = rw;
               cnt_nxt   = T1_LOAD;
            end
         end
         PIO_SETUP: begin
            if (as_n) begin
               state_nxt = PIO_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nxt = PIO_STROBE;
               cnt_nxt   = T2_LOAD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         PIO_STROBE: begin
            if (as_n) begin
               state_nxt = (T2I_CYC == 0) ? PIO_IDLE : PIO_RECOVER;
               cnt_nxt   = T2I_LOAD;
            end else if (cnt == 4'd0) begin
               if (iordy_s) begin
                  state_nxt = PIO_ACK;
               end else begin
                  state_nxt = PIO_WAIT_RDY;
                  tcnt_nxt  = RDY_LOAD;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         PIO_WAIT_RDY: begin
            // An aborting as_n wins over both IORDY and the timeout.
            if (as_n) begin
               state_nxt = (T2I_CYC == 0) ? PIO_IDLE : PIO_RECOVER;
               cnt_nxt   = T2I_LOAD;
               tcnt_nxt  = 8'd0;
            end else if (iordy_s) begin
               state_nxt = PIO_ACK;
               tcnt_nxt  = 8'd0;
            end else if (tcnt == 8'd0) begin
               state_nxt   = PIO_ACK;
               timeout_nxt = 1'b1;
            end else begin
               tcnt_nxt = tcnt - 8'd1;
            end
         end
         PIO_ACK: begin
            if (as_n) begin
               state_nxt = (T2I_CYC == 0) ? PIO_IDLE : PIO_RECOVER;
               cnt_nxt   = T2I_LOAD;
            end
         end
         PIO_RECOVER: begin
            if (cnt == 4'd0) begin
               state_nxt = PIO_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = PIO_IDLE;
            cnt_nxt   = 4'd0;
            tcnt_nxt  = 8'd0;
         end
      endcase
      strobe_nxt = (state_nxt == PIO_STROBE) || (state_nxt == PIO_WAIT_RDY);
   end

   assign busy      = (state != PIO_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for ide_pio_sequencer: a default-timing instance (a_*) and a
// T1=3/T2=6/T2I=0/RDY_TIMEOUT=8 instance (b_*) driven from shared inputs.
module tb_ide_pio_sequencer;

   logic clk, reset_n, req, rw, as_n, iordy;
   logic a_ior_n, a_iow_n, a_dtack, a_busy, a_timeout;
   logic b_ior_n, b_iow_n, b_dtack, b_busy, b_timeout;
   logic [2:0] a_state, b_state;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic req, rw, as_n;
      logic exp_ior_n, exp_iow_n, exp_dtack, exp_busy, exp_timeout;
   } vec_t;
   vec_t rd_tbl[11];

   ide_pio_sequencer dut_a (
      .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .as_n(as_n), .iordy(iordy),
      .ior_n(a_ior_n), .iow_n(a_iow_n), .dtack(a_dtack), .busy(a_busy),
      .timeout(a_timeout), .state_dbg(a_state)
   );

   ide_pio_sequencer #(.T1_CYC(3), .T2_CYC(6), .T2I_CYC(0), .RDY_TIMEOUT(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .as_n(as_n), .iordy(iordy),
      .ior_n(b_ior_n), .iow_n(b_iow_n), .dtack(b_dtack), .busy(b_busy),
      .timeout(b_timeout), .state_dbg(b_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int e, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%b expected=%b", name, e, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 200; n++) begin
         if (!a_busy && !b_busy) break;
         tick();
      end
      chk("idle_bound", 0, a_busy | b_busy, 1'b0);
      repeat (3) tick();
   endtask

   initial begin
      int pulses;
      reset_n = 1'b0; req = 1'b0; rw = 1'b1; as_n = 1'b1; iordy = 1'b1;

      // Default read, iordy ready: strobe low edges 2..5, dtack from 6.
      //            req   rw    as_n  ior   iow   dtack busy  tmo
      rd_tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rd_tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rd_tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      rd_tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_ior_n", 0, a_ior_n, 1'b1);
      chk("rst_a_iow_n", 0, a_iow_n, 1'b1);
      chk("rst_a_dtack", 0, a_dtack, 1'b0);
      chk("rst_a_busy", 0, a_busy, 1'b0);
      chk("rst_a_timeout", 0, a_timeout, 1'b0);
      chk("rst_a_idle_state", 0, a_state == 3'd0, 1'b1);
      chk("rst_b_ior_n", 0, b_ior_n, 1'b1);
      chk("rst_b_dtack", 0, b_dtack, 1'b0);
      @(negedge clk) reset_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         req = rd_tbl[i].req; rw = rd_tbl[i].rw; as_n = rd_tbl[i].as_n;
         tick();
         chk("tbl_ior_n", i, a_ior_n, rd_tbl[i].exp_ior_n);
         chk("tbl_iow_n", i, a_iow_n, rd_tbl[i].exp_iow_n);
         chk("tbl_dtack", i, a_dtack, rd_tbl[i].exp_dtack);
         chk("tbl_busy", i, a_busy, rd_tbl[i].exp_busy);
         chk("tbl_timeout", i, a_timeout, rd_tbl[i].exp_timeout);
      end
      wait_idle();

      // Write on the T1=3/T2=6 instance: iow_n low edges 3..8.
      req = 1'b1; rw = 1'b0; as_n = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk("wr_iow_n", e, b_iow_n, !(e >= 3 && e <= 8));
         chk("wr_ior_n", e, b_ior_n, 1'b1);
         chk("wr_dtack", e, b_dtack, e == 9);
      end
      req = 1'b0; as_n = 1'b1;
      tick();
      chk("wr_t2i0_idle", 10, b_busy, 1'b0);
      chk("wr_dtack_drop", 10, b_dtack, 1'b0);
      wait_idle();

      // IORDY stretch on default instance.
      iordy = 1'b0;
      repeat (3) tick();
      req = 1'b1; rw = 1'b1; as_n = 1'b0;
      for (int e = 0; e < 16; e++) begin
         tick();
         chk("str_ior_n", e, a_ior_n, !(e >= 2 && e <= 13));
         chk("str_dtack", e, a_dtack, e >= 14);
         chk("str_timeout", e, a_timeout, 1'b0);
         if (e == 11) iordy = 1'b1;
      end
      req = 1'b0; as_n = 1'b1;
      wait_idle();

      // IORDY stuck low on RDY_TIMEOUT=8 instance.
      iordy = 1'b0;
      repeat (3) tick();
      req = 1'b1; rw = 1'b1; as_n = 1'b0;
      pulses = 0;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (b_timeout) pulses++;
         chk("to_ior_n", e, b_ior_n, !(e >= 3 && e <= 16));
         chk("to_dtack", e, b_dtack, e >= 17);
         chk("to_timeout", e, b_timeout, e == 17);
      end
      chk("to_single_pulse", 20, pulses == 1, 1'b1);
      req = 1'b0; as_n = 1'b1;
      iordy = 1'b1;
      wait_idle();

      // Abort during SETUP: no strobe, no dtack.
      req = 1'b1; rw = 1'b1; as_n = 1'b0;
      tick();
      chk("abs_busy", 0, a_busy, 1'b1);
      req = 1'b0; as_n = 1'b1;
      for (int e = 1; e < 6; e++) begin
         tick();
         chk("abs_busy", e, a_busy, 1'b0);
         chk("abs_ior_n", e, a_ior_n, 1'b1);
         chk("abs_dtack", e, a_dtack, 1'b0);
      end
      wait_idle();

      // Abort during STROBE: strobe released next edge, two RECOVER cycles.
      req = 1'b1; rw = 1'b1; as_n = 1'b0;
      repeat (4) tick();
      chk("abt_ior_low", 3, a_ior_n, 1'b0);
      req = 1'b0; as_n = 1'b1;
      tick();
      chk("abt_ior_n", 4, a_ior_n, 1'b1);
      chk("abt_dtack", 4, a_dtack, 1'b0);
      chk("abt_recover", 4, a_state == 3'd5, 1'b1);
      tick();
      chk("abt_busy", 5, a_busy, 1'b1);
      chk("abt_dtack", 5, a_dtack, 1'b0);
      tick();
      chk("abt_idle", 6, a_busy, 1'b0);
      wait_idle();

      // Back-to-back: second request held off by RECOVER, then reset mid-strobe.
      req = 1'b1; rw = 1'b1; as_n = 1'b0;
      repeat (8) tick();
      chk("b2b_dtack", 7, a_dtack, 1'b1);
      req = 1'b0; as_n = 1'b1;
      tick();
      chk("b2b_dtack_drop", 8, a_dtack, 1'b0);
      req = 1'b1; as_n = 1'b0;
      tick();
      chk("b2b_recover", 9, a_state == 3'd5, 1'b1);
      chk("b2b_ior_n", 9, a_ior_n, 1'b1);
      tick();
      chk("b2b_idle", 10, a_busy, 1'b0);
      tick();
      chk("b2b_setup", 11, a_state == 3'd1, 1'b1);
      tick();
      chk("b2b_ior_n", 12, a_ior_n, 1'b1);
      tick();
      chk("b2b_ior_n", 13, a_ior_n, 1'b0);
      tick();
      chk("b2b_ior_n", 14, a_ior_n, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_ior_n", 14, a_ior_n, 1'b1);
      chk("rst_mid_dtack", 14, a_dtack, 1'b0);
      chk("rst_mid_busy", 14, a_busy, 1'b0);
      req = 1'b0; as_n = 1'b1;
      @(negedge clk) reset_n = 1'b1;
      repeat (2) tick();
      chk("post_rst_idle", 0, a_busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
